// File: rtl/ll_window_acc.sv
// Sliding-window line-length accumulator: sums the last DEPTH accepted magnitudes.
// Optional threshold flag output is compiled in when LL_THRESH_EN is defined.
module ll_window_acc #(
    parameter int DIN_W = 33,
    parameter int DEPTH = 16,
    localparam int SUM_W = DIN_W + $clog2(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    input  logic             clr,
    output logic [SUM_W-1:0] ll_out,
    output logic             ll_valid,
    output logic [PTR_W:0]   fill_level
`ifdef LL_THRESH_EN
    ,
    input  logic [SUM_W-1:0] thresh,
    output logic             ll_flag
`endif
);

    typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   LAST_FILL = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W + 1)'(1);

    logic [DIN_W-1:0] r_mem [DEPTH];
    state_t           r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_fill_level;
    logic [SUM_W-1:0] r_sum;
    logic             r_upd;
    logic [SUM_W-1:0] r_ll_out;
    logic             r_ll_valid;

    logic             w_accept;
    logic [SUM_W-1:0] w_din_ext;
    logic [SUM_W-1:0] w_evict;
    logic [SUM_W-1:0] w_new_sum;
    logic [PTR_W-1:0] w_ptr_next;

    // In FILL the slot under wr_ptr has never been written, so nothing is evicted.
    assign w_accept   = din_valid & ~clr;
    assign w_din_ext  = {{(SUM_W - DIN_W){1'b0}}, din};
    assign w_evict    = (r_state == ST_RUN) ? {{(SUM_W - DIN_W){1'b0}}, r_mem[r_wr_ptr]}
                                            : {SUM_W{1'b0}};
    assign w_new_sum  = r_sum + w_din_ext - w_evict;
    assign w_ptr_next = (r_wr_ptr == LAST_PTR) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_ONE;

    // Sample buffer write; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Window FSM, running sum and registered outputs (update lags the accept by one edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_fill_level <= {(PTR_W + 1){1'b0}};
            r_sum        <= {SUM_W{1'b0}};
            r_upd        <= 1'b0;
            r_ll_out     <= {SUM_W{1'b0}};
            r_ll_valid   <= 1'b0;
`ifdef LL_THRESH_EN
            ll_flag      <= 1'b0;
`endif
        end else if (clr) begin
            r_state      <= ST_FILL;
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_fill_level <= {(PTR_W + 1){1'b0}};
            r_sum        <= {SUM_W{1'b0}};
            r_upd        <= 1'b0;
            r_ll_valid   <= 1'b0;
`ifdef LL_THRESH_EN
            ll_flag      <= 1'b0;
`endif
        end else begin
            if (r_upd) begin
                r_ll_out   <= r_sum;
                r_ll_valid <= 1'b1;
`ifdef LL_THRESH_EN
                ll_flag    <= (r_sum > thresh);
`endif
            end else begin
                r_ll_valid <= 1'b0;
            end

            if (w_accept) begin
                r_sum    <= w_new_sum;
                r_wr_ptr <= w_ptr_next;
                case (r_state)
                    ST_FILL: begin
                        r_fill_level <= r_fill_level + FILL_ONE;
                        if (r_fill_level == LAST_FILL) begin
                            r_state <= ST_RUN;
                            r_upd   <= 1'b1;
                        end else begin
                            r_upd   <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        r_upd <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_FILL;
                        r_upd   <= 1'b0;
                    end
                endcase
            end else begin
                r_upd <= 1'b0;
            end
        end
    end

    assign ll_out     = r_ll_out;
    assign ll_valid   = r_ll_valid;
    assign fill_level = r_fill_level;

endmodule

// File: tb/tb_ll_window_acc.sv
// Directed table-driven bench for ll_window_acc with DEPTH=4, DIN_W=33.
module tb_ll_window_acc;

    localparam int DIN_W = 33;
    localparam int DEPTH = 4;
    localparam int SUM_W = 35;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIN_W-1:0] din;
    logic             din_valid;
    logic             clr;
    logic [SUM_W-1:0] ll_out;
    logic             ll_valid;
    logic [PTR_W:0]   fill_level;
`ifdef LL_THRESH_EN
    logic [SUM_W-1:0] thresh;
    logic             ll_flag;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             rst;
        logic             clr;
        logic             vld;
        logic [DIN_W-1:0] din;
        logic             exp_vld;
        logic [SUM_W-1:0] exp_out;
        logic [PTR_W:0]   exp_fill;
    } vec_t;

    vec_t vecs[$];

    ll_window_acc #(.DIN_W(DIN_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .clr        (clr),
        .ll_out     (ll_out),
        .ll_valid   (ll_valid),
        .fill_level (fill_level)
`ifdef LL_THRESH_EN
        ,
        .thresh     (thresh),
        .ll_flag    (ll_flag)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic v, input logic [DIN_W-1:0] d,
                       input logic ev, input logic [SUM_W-1:0] eo, input logic [PTR_W:0] ef);
        vec_t x;
        x.rst = r; x.clr = c; x.vld = v; x.din = d;
        x.exp_vld = ev; x.exp_out = eo; x.exp_fill = ef;
        vecs.push_back(x);
    endtask

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic step(input logic r, input logic c, input logic v, input logic [DIN_W-1:0] d);
        rst = r; clr = c; din_valid = v; din = d;
        @(posedge clk);
        #1;
    endtask

    localparam logic [DIN_W-1:0] MAXV = 33'h1_FFFF_FFFF;
    localparam logic [SUM_W-1:0] MAX4 = 35'd34359738364;

    initial begin
        logic [DIN_W-1:0] seq_a [4];
        logic [SUM_W-1:0] exp_o [4];
        logic             exp_v [4];
        logic             exp_f [4];
        int               waited;
        rst = 1'b1; clr = 1'b0; din_valid = 1'b0; din = 33'd0;
`ifdef LL_THRESH_EN
        thresh = 35'd20;
`endif

        // reset, fill 1..4, wrap with 5 and 10
        add(1'b1, 1'b0, 1'b0, 33'd0,  1'b0, 35'd0,  3'd0);
        add(1'b1, 1'b0, 1'b1, 33'd5,  1'b0, 35'd0,  3'd0);
        add(1'b0, 1'b0, 1'b1, 33'd1,  1'b0, 35'd0,  3'd1);
        add(1'b0, 1'b0, 1'b1, 33'd2,  1'b0, 35'd0,  3'd2);
        add(1'b0, 1'b0, 1'b1, 33'd3,  1'b0, 35'd0,  3'd3);
        add(1'b0, 1'b0, 1'b1, 33'd4,  1'b0, 35'd0,  3'd4);
        add(1'b0, 1'b0, 1'b1, 33'd5,  1'b1, 35'd10, 3'd4);
        add(1'b0, 1'b0, 1'b1, 33'd10, 1'b1, 35'd14, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b1, 35'd22, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b0, 35'd22, 3'd4);
        // sparse samples 5 and 6 with idles between
        add(1'b0, 1'b0, 1'b1, 33'd5,  1'b0, 35'd22, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b1, 35'd24, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b0, 35'd24, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b0, 35'd24, 3'd4);
        add(1'b0, 1'b0, 1'b1, 33'd6,  1'b0, 35'd24, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b1, 35'd26, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b0, 35'd26, 3'd4);
        // clr with a coincident sample, then 7,7,7,7
        add(1'b0, 1'b1, 1'b1, 33'd99, 1'b0, 35'd26, 3'd0);
        add(1'b0, 1'b0, 1'b1, 33'd7,  1'b0, 35'd26, 3'd1);
        add(1'b0, 1'b0, 1'b1, 33'd7,  1'b0, 35'd26, 3'd2);
        add(1'b0, 1'b0, 1'b1, 33'd7,  1'b0, 35'd26, 3'd3);
        add(1'b0, 1'b0, 1'b1, 33'd7,  1'b0, 35'd26, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b1, 35'd28, 3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b0, 35'd28, 3'd4);
        // full-scale samples
        add(1'b1, 1'b0, 1'b0, 33'd0,  1'b0, 35'd0,  3'd0);
        add(1'b0, 1'b0, 1'b1, MAXV,   1'b0, 35'd0,  3'd1);
        add(1'b0, 1'b0, 1'b1, MAXV,   1'b0, 35'd0,  3'd2);
        add(1'b0, 1'b0, 1'b1, MAXV,   1'b0, 35'd0,  3'd3);
        add(1'b0, 1'b0, 1'b1, MAXV,   1'b0, 35'd0,  3'd4);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b1, MAX4,   3'd4);
        add(1'b0, 1'b0, 1'b1, MAXV,   1'b0, MAX4,   3'd4);
        // rst mid-RUN cancels the pending update and returns to FILL
        add(1'b1, 1'b0, 1'b1, MAXV,   1'b0, 35'd0,  3'd0);
        add(1'b0, 1'b0, 1'b1, 33'd1,  1'b0, 35'd0,  3'd1);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b0, 35'd0,  3'd1);
        add(1'b0, 1'b0, 1'b1, 33'd2,  1'b0, 35'd0,  3'd2);
        add(1'b0, 1'b0, 1'b1, 33'd3,  1'b0, 35'd0,  3'd3);
        add(1'b0, 1'b0, 1'b1, 33'd4,  1'b0, 35'd0,  3'd4);
        // clr right after window completion swallows the pending update
        add(1'b0, 1'b1, 1'b0, 33'd0,  1'b0, 35'd0,  3'd0);
        add(1'b0, 1'b0, 1'b0, 33'd0,  1'b0, 35'd0,  3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].din);
            chk($sformatf("row%0d ll_valid", i), 64'(ll_valid),   64'(vecs[i].exp_vld));
            chk($sformatf("row%0d ll_out", i),   64'(ll_out),     64'(vecs[i].exp_out));
            chk($sformatf("row%0d fill", i),     64'(fill_level), 64'(vecs[i].exp_fill));
        end

        // window 5,6,7,8 then bounded wait for the update
        seq_a = '{33'd5, 33'd6, 33'd7, 33'd8};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, seq_a[i]);
        waited = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 33'd0);
            waited++;
        end while (ll_valid !== 1'b1 && waited < 6);
        chk("win26 latency", 64'(waited), 64'd1);
        chk("win26 ll_out", 64'(ll_out), 64'd26);
`ifdef LL_THRESH_EN
        chk("win26 ll_flag", 64'(ll_flag), 64'd1);
`endif

        // back-to-back ones evict 5,6,7,8 in turn
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_o = '{35'd26, 35'd22, 35'd17, 35'd11};
        exp_f = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 33'd1);
            chk($sformatf("b2b%0d ll_valid", i), 64'(ll_valid), 64'(exp_v[i]));
            chk($sformatf("b2b%0d ll_out", i),   64'(ll_out),   64'(exp_o[i]));
`ifdef LL_THRESH_EN
            chk($sformatf("b2b%0d ll_flag", i),  64'(ll_flag),  64'(exp_f[i]));
`endif
        end
        step(1'b0, 1'b0, 1'b0, 33'd0);
        chk("ones ll_valid", 64'(ll_valid), 64'd1);
        chk("ones ll_out", 64'(ll_out), 64'd4);
`ifdef LL_THRESH_EN
        chk("ones ll_flag", 64'(ll_flag), 64'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 33'd0);
        chk("ones idle ll_valid", 64'(ll_valid), 64'd0);
        chk("ones idle ll_out", 64'(ll_out), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
